// File: rtl/difftest_commit_queue.sv
// Difftest capture queue: buffers retired-instruction records with CSR snapshots for the
// simulator to drain, keeps a shadow GPR file of drained writes, and runs a no-commit watchdog.
module difftest_commit_queue #(
    parameter int unsigned XLEN      = 32,
    parameter int unsigned NR_COMMIT = 2,
    parameter int unsigned NR_CSR    = 5,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      resetn,
    input  logic [NR_COMMIT-1:0]      commit_valid,
    input  logic [NR_COMMIT*XLEN-1:0] commit_pc,
    input  logic [NR_COMMIT*32-1:0]   commit_inst,
    input  logic [NR_COMMIT-1:0]      commit_wen,
    input  logic [NR_COMMIT*5-1:0]    commit_wdest,
    input  logic [NR_COMMIT*XLEN-1:0] commit_wdata,
    input  logic [NR_COMMIT-1:0]      commit_excp,
    input  logic [NR_CSR*XLEN-1:0]    csr_flat,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [XLEN-1:0]           out_pc,
    output logic [31:0]               out_inst,
    output logic                      out_wen,
    output logic [4:0]                out_wdest,
    output logic [XLEN-1:0]           out_wdata,
    output logic                      out_excp,
    output logic [NR_CSR*XLEN-1:0]    out_csr,
    output logic [31:0]               out_seq,
    output logic [32*XLEN-1:0]        shadow_gpr,
    output logic [$clog2(DEPTH):0]    occupancy,
    output logic                      almost_full,
    output logic                      overflow,
    output logic                      timeout
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned OW = AW + 1;
    localparam int unsigned CW = NR_CSR * XLEN;
    localparam logic [OW-1:0] DEPTH_W = OW'(DEPTH);
    localparam logic [OW-1:0] NRC_W   = OW'(NR_COMMIT);

    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [31:0]     inst_mem  [DEPTH];
    logic [4:0]      wdest_mem [DEPTH];
    logic [XLEN-1:0] wdata_mem [DEPTH];
    logic [CW-1:0]   csr_mem   [DEPTH];
    logic [31:0]     seq_mem   [DEPTH];
    logic [DEPTH-1:0] wen_mem;
    logic [DEPTH-1:0] excp_mem;

    logic [AW-1:0]   head_q, tail_q;
    logic [OW-1:0]   occ_q, occ_d;
    logic [31:0]     seq_q;
    logic            overflow_q;
    logic            timeout_q;
    logic [XLEN-1:0] gpr_q [31:1];

    logic [OW-1:0]   grp_n;
    logic [OW-1:0]   free;
    logic            accept;
    logic            deq;
    logic            gap;
    logic [AW-1:0]   slot [NR_COMMIT];

    // Group size stops at the first clear valid bit; lanes above a gap are ignored.
    always_comb begin
        grp_n = '0;
        gap   = 1'b0;
        for (int i = 0; i < NR_COMMIT; i++) begin
            if (!gap && commit_valid[i]) begin
                grp_n = OW'(i + 1);
            end else begin
                gap = 1'b1;
            end
        end
    end

    // Space is judged on start-of-cycle occupancy; a same-cycle pop does not help.
    always_comb begin
        free   = DEPTH_W - occ_q;
        accept = (grp_n != '0) && (free >= grp_n);
        deq    = out_valid && out_ready;
        occ_d  = occ_q + (accept ? grp_n : '0) - OW'(deq);
        for (int i = 0; i < NR_COMMIT; i++) begin
            slot[i] = tail_q + AW'(i);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NR_COMMIT; i++) begin
            if (accept && (OW'(i) < grp_n)) begin
                pc_mem[slot[i]]    <= commit_pc[i*XLEN +: XLEN];
                inst_mem[slot[i]]  <= commit_inst[i*32 +: 32];
                wdest_mem[slot[i]] <= commit_wdest[i*5 +: 5];
                wdata_mem[slot[i]] <= commit_wdata[i*XLEN +: XLEN];
                csr_mem[slot[i]]   <= csr_flat;
                seq_mem[slot[i]]   <= seq_q + 32'(i);
                excp_mem[slot[i]]  <= commit_excp[i];
                wen_mem[slot[i]]   <= commit_wen[i] && (commit_wdest[i*5 +: 5] != 5'd0)
                                      && !commit_excp[i];
            end
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            head_q     <= '0;
            tail_q     <= '0;
            occ_q      <= '0;
            seq_q      <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                tail_q <= tail_q + AW'(grp_n);
                seq_q  <= seq_q + 32'(grp_n);
            end
            if (grp_n != '0 && !accept) begin
                overflow_q <= 1'b1;
            end
            if (deq) begin
                head_q <= head_q + AW'(1);
            end
            occ_q <= occ_d;
        end
    end

    // Stored wen is pre-masked, so r0 is never written.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int r = 1; r < 32; r++) begin
                gpr_q[r] <= '0;
            end
        end else if (deq && out_wen) begin
            gpr_q[out_wdest] <= out_wdata;
        end
    end

    generate
        if (TIMEOUT > 0) begin : g_wd
            localparam int unsigned WW = $clog2(TIMEOUT + 1);
            localparam logic [WW-1:0] TMAX = WW'(TIMEOUT);
            logic [WW-1:0] wd_q, wd_d;

            always_comb begin
                wd_d = wd_q;
                if (grp_n != '0) begin
                    wd_d = '0;
                end else if (wd_q != TMAX) begin
                    wd_d = wd_q + WW'(1);
                end
            end

            always_ff @(posedge clk or negedge resetn) begin
                if (!resetn) begin
                    wd_q      <= '0;
                    timeout_q <= 1'b0;
                end else begin
                    wd_q <= wd_d;
                    if (wd_d == TMAX) begin
                        timeout_q <= 1'b1;
                    end
                end
            end
        end else begin : g_no_wd
            assign timeout_q = 1'b0;
        end
    endgenerate

    // Head fields are forced to zero while empty so stale storage never leaks out.
    always_comb begin
        out_valid   = (occ_q != '0);
        out_pc      = out_valid ? pc_mem[head_q]    : '0;
        out_inst    = out_valid ? inst_mem[head_q]  : '0;
        out_wen     = out_valid ? wen_mem[head_q]   : 1'b0;
        out_wdest   = out_valid ? wdest_mem[head_q] : '0;
        out_wdata   = out_valid ? wdata_mem[head_q] : '0;
        out_excp    = out_valid ? excp_mem[head_q]  : 1'b0;
        out_csr     = out_valid ? csr_mem[head_q]   : '0;
        out_seq     = out_valid ? seq_mem[head_q]   : '0;
        occupancy   = occ_q;
        almost_full = (DEPTH_W - occ_q) < NRC_W;
        overflow    = overflow_q;
        timeout     = timeout_q;
        shadow_gpr  = '0;
        for (int r = 1; r < 32; r++) begin
            shadow_gpr[r*XLEN +: XLEN] = gpr_q[r];
        end
    end

endmodule

// File: tb/tb_difftest_commit_queue.sv
// Directed bench for difftest_commit_queue: vector table for basic enqueue/drain plus
// hand sequences for watchdog, fill/overflow, async reset and sustained streaming.
module tb_difftest_commit_queue;

    localparam int XLEN  = 32;
    localparam int NC    = 2;
    localparam int NCSR  = 5;
    localparam int DEPTH = 16;
    localparam int TO    = 8;

    logic              clk;
    logic              resetn;
    logic [NC-1:0]     commit_valid;
    logic [NC*XLEN-1:0] commit_pc;
    logic [NC*32-1:0]  commit_inst;
    logic [NC-1:0]     commit_wen;
    logic [NC*5-1:0]   commit_wdest;
    logic [NC*XLEN-1:0] commit_wdata;
    logic [NC-1:0]     commit_excp;
    logic [NCSR*XLEN-1:0] csr_flat;
    logic              out_valid;
    logic              out_ready;
    logic [XLEN-1:0]   out_pc;
    logic [31:0]       out_inst;
    logic              out_wen;
    logic [4:0]        out_wdest;
    logic [XLEN-1:0]   out_wdata;
    logic              out_excp;
    logic [NCSR*XLEN-1:0] out_csr;
    logic [31:0]       out_seq;
    logic [32*XLEN-1:0] shadow_gpr;
    logic [4:0]        occupancy;
    logic              almost_full;
    logic              overflow;
    logic              timeout;

    int checks = 0;
    int errors = 0;

    difftest_commit_queue #(
        .XLEN(XLEN), .NR_COMMIT(NC), .NR_CSR(NCSR), .DEPTH(DEPTH), .TIMEOUT(TO)
    ) dut (
        .clk(clk), .resetn(resetn),
        .commit_valid(commit_valid), .commit_pc(commit_pc), .commit_inst(commit_inst),
        .commit_wen(commit_wen), .commit_wdest(commit_wdest), .commit_wdata(commit_wdata),
        .commit_excp(commit_excp), .csr_flat(csr_flat),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_wen(out_wen), .out_wdest(out_wdest), .out_wdata(out_wdata), .out_excp(out_excp),
        .out_csr(out_csr), .out_seq(out_seq), .shadow_gpr(shadow_gpr),
        .occupancy(occupancy), .almost_full(almost_full), .overflow(overflow),
        .timeout(timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  v;
        logic [31:0] pc0, pc1;
        logic [1:0]  wen;
        logic [4:0]  wd0, wd1;
        logic [31:0] d0, d1;
        logic [1:0]  ex;
        logic        rdy;
        int          occ;
        logic        val;
        logic [31:0] pc;
        logic [31:0] seq;
        logic        wen_o;
        logic        ex_o;
        int          reg_i;
        logic [31:0] reg_v;
    } vec_t;

    vec_t vecs [11];

    task automatic chk(input string nm, input logic [159:0] act, input logic [159:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // One group of wen=0 records; lane PCs encode the sequence number they should receive.
    task automatic drive_grp(input int lanes, input logic [31:0] base, input logic [31:0] csr);
        commit_valid = (lanes == 2) ? 2'b11 : 2'b01;
        commit_pc    = {32'h2000_0000 + (base + 1) * 4, 32'h2000_0000 + base * 4};
        commit_wen   = 2'b00;
        commit_excp  = 2'b00;
        csr_flat     = {NCSR{csr}};
        step();
        commit_valid = 2'b00;
    endtask

    initial begin
        logic [31:0] nseq;
        commit_valid = '0; commit_pc = '0; commit_inst = '0; commit_wen = '0;
        commit_wdest = '0; commit_wdata = '0; commit_excp = '0; csr_flat = '0;
        out_ready = 1'b1;
        resetn = 1'b0;

        vecs[0]  = '{2'b11, 32'h1c000000, 32'h1c000004, 2'b11, 5'd4, 5'd5, 32'h11, 32'h22,
                     2'b00, 1'b0, 2, 1'b1, 32'h1c000000, 32'd0, 1'b1, 1'b0, 4, 32'h0};
        vecs[1]  = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 1, 1'b1, 32'h1c000004, 32'd1, 1'b1, 1'b0, 4, 32'h11};
        vecs[2]  = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 5, 32'h22};
        vecs[3]  = '{2'b11, 32'h1c000008, 32'h1c00000c, 2'b11, 5'd0, 5'd6, 32'hdead, 32'h66,
                     2'b10, 1'b0, 2, 1'b1, 32'h1c000008, 32'd2, 1'b0, 1'b0, 0, 32'h0};
        vecs[4]  = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 1, 1'b1, 32'h1c00000c, 32'd3, 1'b0, 1'b1, 0, 32'h0};
        vecs[5]  = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 6, 32'h0};
        vecs[6]  = '{2'b10, 32'h1c0000f0, 32'h1c0000f4, 2'b11, 5'd10, 5'd11, 32'haa, 32'hbb,
                     2'b00, 1'b0, 0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 10, 32'h0};
        vecs[7]  = '{2'b01, 32'h1c000010, 32'h0, 2'b01, 5'd7, 5'd0, 32'h77, 32'h0,
                     2'b00, 1'b1, 1, 1'b1, 32'h1c000010, 32'd4, 1'b1, 1'b0, 7, 32'h0};
        vecs[8]  = '{2'b11, 32'h1c000014, 32'h1c000018, 2'b11, 5'd8, 5'd9, 32'h88, 32'h99,
                     2'b00, 1'b1, 2, 1'b1, 32'h1c000014, 32'd5, 1'b1, 1'b0, 7, 32'h77};
        vecs[9]  = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 1, 1'b1, 32'h1c000018, 32'd6, 1'b1, 1'b0, 8, 32'h88};
        vecs[10] = '{2'b00, 32'h0, 32'h0, 2'b00, 5'd0, 5'd0, 32'h0, 32'h0,
                     2'b00, 1'b1, 0, 1'b0, 32'h0, 32'd0, 1'b0, 1'b0, 9, 32'h99};

        // Reset state
        #2;
        chk("rst_valid", out_valid, 0);
        chk("rst_occ", occupancy, 0);
        chk("rst_shadow_zero", shadow_gpr == '0, 1);
        chk("rst_overflow", overflow, 0);
        chk("rst_timeout", timeout, 0);
        chk("rst_almost_full", almost_full, 0);
        chk("rst_pc", out_pc, 0);
        @(posedge clk);
        #1 resetn = 1'b1;

        // Watchdog: 7 idle edges not yet expired, 8th sets the sticky flag
        repeat (TO - 1) step();
        chk("wd_before", timeout, 0);
        chk("idle_valid", out_valid, 0);
        step();
        chk("wd_expire", timeout, 1);
        repeat (3) step();
        chk("wd_sticky", timeout, 1);

        // Table-driven basic enqueue/drain, masking and gap handling
        for (int i = 0; i < 11; i++) begin
            commit_valid = vecs[i].v;
            commit_pc    = {vecs[i].pc1, vecs[i].pc0};
            commit_wen   = vecs[i].wen;
            commit_wdest = {vecs[i].wd1, vecs[i].wd0};
            commit_wdata = {vecs[i].d1, vecs[i].d0};
            commit_excp  = vecs[i].ex;
            out_ready    = vecs[i].rdy;
            step();
            chk($sformatf("v%0d_occ", i), occupancy, vecs[i].occ);
            chk($sformatf("v%0d_valid", i), out_valid, vecs[i].val);
            chk($sformatf("v%0d_pc", i), out_pc, vecs[i].pc);
            chk($sformatf("v%0d_seq", i), out_seq, vecs[i].seq);
            chk($sformatf("v%0d_wen", i), out_wen, vecs[i].wen_o);
            chk($sformatf("v%0d_excp", i), out_excp, vecs[i].ex_o);
            chk($sformatf("v%0d_gpr", i), shadow_gpr[vecs[i].reg_i*32 +: 32], vecs[i].reg_v);
        end
        commit_valid = '0;
        chk("pre_fill_overflow", overflow, 0);

        // Fill, drop at 15 and 16, accept a single lane at 15
        out_ready = 1'b0;
        nseq = 32'd7;
        for (int g = 0; g < 7; g++) begin
            drive_grp(2, nseq, 32'hc000_0000 + g);
            nseq += 2;
        end
        chk("fill14_occ", occupancy, 14);
        chk("fill14_af", almost_full, 0);
        drive_grp(1, nseq, 32'hc000_0007);
        nseq += 1;
        chk("fill15_occ", occupancy, 15);
        chk("fill15_af", almost_full, 1);
        chk("fill15_ovf", overflow, 0);
        drive_grp(2, nseq, 32'hc000_0008);
        chk("drop15_occ", occupancy, 15);
        chk("drop15_ovf", overflow, 1);
        drive_grp(1, nseq, 32'hc000_0009);
        nseq += 1;
        chk("fill16_occ", occupancy, 16);
        drive_grp(2, nseq, 32'hc000_000a);
        chk("drop16_occ", occupancy, 16);
        chk("drop16_ovf", overflow, 1);

        out_ready = 1'b1;
        for (int j = 0; j < 16; j++) begin
            chk($sformatf("drain%0d_seq", j), out_seq, 32'd7 + j);
            chk($sformatf("drain%0d_pc", j), out_pc, 32'h2000_0000 + (32'd7 + j) * 4);
            if (j < 3) begin
                chk($sformatf("drain%0d_csr", j), out_csr,
                    {NCSR{32'hc000_0000 + ((j < 2) ? 32'd0 : 32'd1)}});
            end
            step();
        end
        chk("drained_occ", occupancy, 0);
        chk("drained_valid", out_valid, 0);

        // Dropped groups must not have advanced the sequence counter
        out_ready = 1'b0;
        drive_grp(1, nseq, 32'h0);
        chk("post_drop_seq", out_seq, 32'd23);
        drive_grp(2, nseq + 1, 32'h0);
        drive_grp(2, nseq + 3, 32'h0);
        chk("pre_rst_occ", occupancy, 5);

        // Asynchronous reset mid-drain
        out_ready = 1'b1;
        #2 resetn = 1'b0;
        #1;
        chk("arst_valid", out_valid, 0);
        chk("arst_occ", occupancy, 0);
        chk("arst_ovf", overflow, 0);
        chk("arst_timeout", timeout, 0);
        chk("arst_shadow_zero", shadow_gpr == '0, 1);
        chk("arst_pc", out_pc, 0);
        #1 resetn = 1'b1;

        // Sustained one commit per cycle with concurrent drain; pointers wrap twice
        nseq = 32'd0;
        for (int c = 0; c < 40; c++) begin
            commit_valid = 2'b01;
            commit_pc    = {32'h0, 32'h3000_0000 + nseq * 4};
            commit_wen   = 2'b01;
            commit_wdest = {5'd0, 5'd1};
            commit_wdata = {32'h0, 32'(c)};
            commit_excp  = 2'b00;
            step();
            chk($sformatf("sus%0d_occ", c), occupancy, 1);
            chk($sformatf("sus%0d_seq", c), out_seq, nseq);
            nseq += 1;
        end
        commit_valid = '0;
        chk("sus_gpr1", shadow_gpr[1*32 +: 32], 32'd38);
        chk("sus_ovf", overflow, 0);
        chk("sus_timeout", timeout, 0);
        step();
        chk("sus_final_occ", occupancy, 0);
        chk("sus_final_gpr1", shadow_gpr[1*32 +: 32], 32'd39);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/difftest_commit_queue.md
Name: difftest_commit_queue

Overview:
Parametrised difftest capture block. Buffers up to NR_COMMIT retired-instruction records per cycle, each with a CSR snapshot, in a DEPTH-entry FIFO. The simulator drains the FIFO one record per valid/ready handshake. Keeps a shadow GPR file updated from the drained writes, so the exported register state always matches the last drained instruction. Also provides a no-commit watchdog and sticky overflow/timeout flags; it sits beside the core's commit stage and is passive, never stalling the pipeline.

Parameters:
XLEN, 32, data/PC/register width
NR_COMMIT, 2, commit lanes per cycle (1..4)
NR_CSR, 5, CSRs snapshotted per record (order crmd, prmd, estat, era, eentry, then extras)
DEPTH, 16, FIFO entries, power of 2, >= NR_COMMIT
TIMEOUT, 4096, cycles without commit before timeout flag; 0 disables watchdog

Ports:
clk  in  1  clock
resetn  in  1  asynchronous active-low reset
commit_valid  in  NR_COMMIT  per-lane retire valid; lanes contiguous from lane 0
commit_pc  in  NR_COMMIT*XLEN  per-lane PC
commit_inst  in  NR_COMMIT*32  per-lane instruction word
commit_wen  in  NR_COMMIT  per-lane GPR write enable
commit_wdest  in  NR_COMMIT*5  per-lane destination register
commit_wdata  in  NR_COMMIT*XLEN  per-lane write data
commit_excp  in  NR_COMMIT  lane raised exception (instruction not executed)
csr_flat  in  NR_CSR*XLEN  CSR values after this cycle's commits
out_valid  out  1  head record available
out_ready  in  1  simulator accepts head record
out_pc  out  XLEN  head PC
out_inst  out  32  head instruction
out_wen  out  1  head GPR write (already masked: 0 if wdest==0 or excp)
out_wdest  out  5  head destination
out_wdata  out  XLEN  head write data
out_excp  out  1  head exception flag
out_csr  out  NR_CSR*XLEN  head CSR snapshot
out_seq  out  32  head sequence number
shadow_gpr  out  32*XLEN  shadow register file, reg 0 at LSBs
occupancy  out  log2(DEPTH)+1  current entry count
almost_full  out  1  DEPTH-occupancy < NR_COMMIT
overflow  out  1  sticky: a commit group was dropped
timeout  out  1  sticky: watchdog expired

Behaviour:
- Reset (resetn low, async): FIFO empty, occupancy 0, out_valid 0, all out_* data 0, seq counter 0, shadow_gpr all 0, watchdog 0, overflow 0, timeout 0, almost_full 0 (NR_COMMIT<=DEPTH). Reset mid-operation discards all entries immediately.
- Group size n = number of set commit_valid bits. Non-contiguous valid (gap below a set lane) is treated as n = index of first clear bit; lanes above the gap are ignored.
- Enqueue: if n>0 and DEPTH-occupancy_at_cycle_start >= n, lanes 0..n-1 are written in lane order at consecutive tail slots in one cycle. Same-cycle dequeue does not free space for that cycle's enqueue.
- Drop: if free < n, the whole group is discarded (no partial enqueue), overflow set and held until reset, seq counter unchanged.
- Every lane of an accepted group stores the same csr_flat value.
- Seq: each enqueued record gets the current 32-bit counter, then counter+1 per record; wraps 0xFFFFFFFF->0.
- Dequeue: out_* show the head combinationally from storage; out_valid = occupancy!=0. On out_valid&&out_ready, head pointer advances. Enqueue and dequeue in the same cycle are both applied: occupancy += n - 1.
- Shadow GPR: on dequeue, if out_wen, shadow_gpr[out_wdest] <= out_wdata. Register 0 always reads 0.
- Pointers: log2(DEPTH)-bit head/tail, wrap modulo DEPTH; occupancy is a separate counter with range 0..DEPTH.
- Watchdog (TIMEOUT>0): counter resets to 0 in any cycle with n>0, else increments; saturates at TIMEOUT. When it reaches TIMEOUT, timeout is set and held until reset. Dropped groups still count as commits.
- almost_full is combinational from occupancy.

Test Plan:
- Reset then idle, out_ready=1: out_valid 0, occupancy 0, shadow_gpr 0; after TIMEOUT=8 idle cycles timeout=1 and stays 1.
- Two-lane commit pc=0x1c000000/0x1c000004, wen=1 wdest=4/5 wdata=0x11/0x22, out_ready=0 -> occupancy 2, seq 0 then 1. Raise out_ready for 2 cycles -> records drained in order, shadow r4=0x11, r5=0x22.
- Commit with wdest=0 wdata=0xdead, and an excp lane with wen=1 wdest=6 -> out_wen 0 for both; shadow r0 and r6 unchanged.
- Fill DEPTH=16 with out_ready=0, then a 2-lane group -> group dropped, overflow=1, occupancy 16, next seq unchanged. At occupancy 15, a 2-lane group is also dropped; a 1-lane group is accepted.
- Sustained 1 commit/cycle with out_ready=1 across 40 cycles -> occupancy constant, seq wraps pointers correctly, no overflow.
- Assert resetn low mid-drain with occupancy 5 -> out_valid 0 immediately (async), occupancy 0, flags cleared, shadow zeroed.
